// File: rtl/mb_sync_rx_mc.sv
// rtl/mb_sync_rx_mc.sv - multichannel toggle req/ack CDC receiver with round-robin merge
module mb_sync_rx_mc #(
    parameter int NB    = 8,
    parameter int NCH   = 4,
    parameter int NSYNC = 2,
    localparam int CW   = $clog2(NCH)
) (
    input  logic              i_dest_clock,
    input  logic              i_reset_n,
    input  logic [NCH-1:0]    i_req_tgl,
    input  logic [NCH*NB-1:0] i_data,
    output logic [NCH-1:0]    o_ack_tgl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NB-1:0]     o_data,
    output logic [CW-1:0]     o_ch,
    input  logic              i_ovr_clr,
    output logic [NCH-1:0]    o_overrun
);

    (* ASYNC_REG = "TRUE" *) logic [NCH-1:0] sync_q [NSYNC];
    logic [NCH-1:0] req_d;
    logic [NCH-1:0] pending;
    logic [NB-1:0]  hold [NCH];
    logic [CW-1:0]  ptr;

    logic [NCH-1:0] evt, busy, cap, ovr, grant_mask, ack_flip;
    logic [CW-1:0]  grant;
    logic           found, load, accept;
    int             idx;

    // A channel is busy from capture until its word leaves the output register.
    always_comb begin
        busy = pending;
        if (o_valid) busy[o_ch] = 1'b1;
        evt = sync_q[NSYNC-1] ^ req_d;
        cap = evt & ~busy;
        ovr = evt & busy;
    end

    // First pending channel at or after the pointer, wrapping.
    always_comb begin
        grant = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && pending[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    assign load       = (!o_valid || i_ready) && found;
    assign accept     = o_valid && i_ready;
    assign grant_mask = load ? (NCH'(1) << grant) : '0;
    assign ack_flip   = accept ? (NCH'(1) << o_ch) : '0;

    always_ff @(posedge i_dest_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int s = 0; s < NSYNC; s++) sync_q[s] <= '0;
            for (int c = 0; c < NCH; c++) hold[c] <= '0;
            req_d     <= '0;
            pending   <= '0;
            ptr       <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_ch      <= '0;
            o_ack_tgl <= '0;
            o_overrun <= '0;
        end else begin
            sync_q[0] <= i_req_tgl;
            for (int s = 1; s < NSYNC; s++) sync_q[s] <= sync_q[s-1];
            req_d <= sync_q[NSYNC-1];
            for (int c = 0; c < NCH; c++) begin
                if (cap[c]) hold[c] <= i_data[c*NB +: NB];
            end
            pending   <= (pending & ~grant_mask) | cap;
            o_overrun <= (o_overrun & ~{NCH{i_ovr_clr}}) | ovr;
            o_ack_tgl <= o_ack_tgl ^ ack_flip;
            if (load) begin
                o_data  <= hold[grant];
                o_ch    <= grant;
                o_valid <= 1'b1;
                ptr     <= (grant == CW'(NCH-1)) ? '0 : grant + CW'(1);
            end else if (accept) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mb_sync_rx_mc.sv
// tb/tb_mb_sync_rx_mc.sv - self-checking bench for mb_sync_rx_mc
module tb_mb_sync_rx_mc;

    localparam int NB    = 8;
    localparam int NCH   = 4;
    localparam int NSYNC = 2;
    localparam int CW    = $clog2(NCH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH*NB-1:0] data = '0;
    logic [NCH-1:0]    ack;
    logic              valid;
    logic              ready = 1'b0;
    logic [NB-1:0]     odata;
    logic [CW-1:0]     och;
    logic              ovr_clr = 1'b0;
    logic [NCH-1:0]    ovr;

    always #5 clk = ~clk;

    mb_sync_rx_mc #(.NB(NB), .NCH(NCH), .NSYNC(NSYNC)) dut (
        .i_dest_clock (clk),
        .i_reset_n    (rst_n),
        .i_req_tgl    (req),
        .i_data       (data),
        .o_ack_tgl    (ack),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (odata),
        .o_ch         (och),
        .i_ovr_clr    (ovr_clr),
        .o_overrun    (ovr)
    );

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [NB-1:0] d;
    } word_t;

    typedef struct {
        int            ch;
        logic [NB-1:0] d;
        int            lat;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    word_t sb[$];
    int    acc_log[$];
    int    auto_prob [NCH];
    vec_t  vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int c, input logic [NB-1:0] d);
        data[c*NB +: NB] = d;
        req[c] = ~req[c];
        sb.push_back('{ch: CW'(c), d: d});
    endtask

    // Each channel delivers its words in order; match against the oldest outstanding one.
    task automatic sb_match(input logic [CW-1:0] c, input logic [NB-1:0] d);
        int k;
        k = -1;
        for (int i = 0; i < sb.size(); i++) if (k < 0 && sb[i].ch == c) k = i;
        chk("word_expected", 32'(k >= 0), 32'd1);
        if (k >= 0) begin
            chk("word_data", 32'(d), 32'(sb[k].d));
            sb.delete(k);
        end
    endtask

    task automatic tick();
        logic          pv, pr;
        logic [NB-1:0] pd;
        logic [CW-1:0] pc;
        logic [NCH-1:0] pa;
        pv = valid; pr = ready; pd = odata; pc = och; pa = ack;
        @(posedge clk);
        #1;
        if (pv && pr) begin
            chk("ack_on_accept", 32'(ack), 32'(pa ^ (NCH'(1) << pc)));
            acc_log.push_back(int'(pc));
            sb_match(pc, pd);
        end else begin
            chk("ack_idle", 32'(ack), 32'(pa));
            if (pv) begin
                chk("stall_valid", 32'(valid), 32'd1);
                chk("stall_data", 32'(odata), 32'(pd));
                chk("stall_ch", 32'(och), 32'(pc));
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (auto_prob[c] > 0 && req[c] == ack[c] && $urandom_range(1, 100) <= auto_prob[c])
                send(c, NB'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        data = '0;
        ready = 1'b0;
        ovr_clr = 1'b0;
        for (int c = 0; c < NCH; c++) auto_prob[c] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        acc_log.delete();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 30) begin
            tick();
            n++;
        end
        chk("valid_seen", 32'(valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        ready = 1'b1;
        send(v.ch, v.d);
        wait_valid(n);
        chk("vec_latency", 32'(n), 32'(v.lat));
        chk("vec_ch", 32'(och), 32'(v.ch));
        chk("vec_data", 32'(odata), 32'(v.d));
        tick();
        chk("vec_ack", 32'(ack[v.ch]), 32'(req[v.ch]));
        repeat (3) tick();
        chk("vec_idle", 32'(valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{1, 8'hA5, NSYNC + 2};
        vecs[1] = '{0, 8'h3C, NSYNC + 2};
        vecs[2] = '{3, 8'hFF, NSYNC + 2};
        vecs[3] = '{2, 8'h00, NSYNC + 2};

        do_reset();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(odata), 32'd0);
        chk("rst_ch", 32'(och), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // All channels at once: round-robin from pointer 0, one word per cycle.
        do_reset();
        ready = 1'b1;
        for (int c = 0; c < NCH; c++) send(c, NB'(8'h10 + c * 8'h11));
        wait_valid(n);
        chk("burst_latency", 32'(n), 32'(NSYNC + 2));
        for (int k = 0; k < NCH; k++) begin
            chk("burst_valid", 32'(valid), 32'd1);
            chk("burst_ch", 32'(och), 32'(k));
            tick();
        end
        chk("burst_acks", 32'(ack), 32'(req));
        chk("burst_drained", 32'(sb.size()), 32'd0);

        // Long backpressure on ch2.
        do_reset();
        send(2, 8'h5A);
        wait_valid(n);
        repeat (20) tick();
        chk("bp_no_ack", 32'(ack), 32'd0);
        chk("bp_data", 32'(odata), 32'h5A);
        ready = 1'b1;
        tick();
        chk("bp_ack", 32'(ack), 32'b0100);
        ready = 1'b0;
        tick();
        chk("bp_single", 32'(ack), 32'b0100);
        chk("bp_valid_low", 32'(valid), 32'd0);

        // Protocol violation: second toggle on ch0 before ack.
        do_reset();
        send(0, 8'h11);
        repeat (6) tick();
        data[0 +: NB] = 8'h22;
        req[0] = ~req[0];
        repeat (5) tick();
        chk("ovr_set", 32'(ovr), 32'b0001);
        chk("ovr_first_data", 32'(odata), 32'h11);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(ovr), 32'd0);
        repeat (6) tick();
        chk("ovr_no_extra", 32'(valid), 32'd0);

        // Two continuously busy channels must alternate.
        do_reset();
        ready = 1'b1;
        auto_prob[0] = 100;
        auto_prob[3] = 100;
        n = 0;
        while (acc_log.size() < 8 && n < 200) begin
            tick();
            n++;
        end
        chk("rr_count", 32'(acc_log.size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < acc_log.size(); k++)
            chk("rr_order", 32'(acc_log[k]), (k % 2 == 0) ? 32'd0 : 32'd3);
        auto_prob[0] = 0;
        auto_prob[3] = 0;
        repeat (10) tick();

        // Reset while a word is held and two more are pending.
        do_reset();
        send(0, 8'hC0);
        send(1, 8'hC1);
        send(2, 8'hC2);
        repeat (6) tick();
        chk("mid_setup_valid", 32'(valid), 32'd1);
        #3;
        rst_n = 1'b0;
        req = '0;
        data = '0;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_data", 32'(odata), 32'd0);
        chk("mid_rst_ch", 32'(och), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        acc_log.delete();
        run_vec(vecs[0]);

        // Randomized compliant sources with random backpressure.
        do_reset();
        for (int c = 0; c < NCH; c++) auto_prob[c] = 30;
        repeat (800) begin
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        for (int c = 0; c < NCH; c++) auto_prob[c] = 0;
        ready = 1'b1;
        repeat (40) tick();
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_no_ovr", 32'(ovr), 32'd0);
        chk("rand_idle", 32'(valid), 32'd0);
        chk("rand_acks", 32'(ack), 32'(req));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
